lms_step_sequencer: RTL and testbench
=====================================

// Module: lms_step_sequencer
// PURPOSE
//  Per-sample controller for the adaptive filter datapath. Accepts a new sample, then runs three stages in order: FIR output,
//  error_check (e = d - y, memory write), and the per-tap weight update. Watches the error magnitude to raise a convergence flag.
//  Catches stalled stages with a watchdog. Sits between the sample source and the fir/error_check/weight-update blocks.
// PARAMETERS
//  NTAPS       4    number of weight taps updated per sample (>=1)
//  TAP_W       2    width of upd_tap, = clog2(NTAPS) (min 1)
//  TIMEOUT     255  max cycles waited for any *_done before abort (1..255)
//  CONV_THRESH 4    |e| <= CONV_THRESH counts as a "good" sample
//  CONV_COUNT  8    consecutive good samples needed to assert converged (1..255)
//  ITER_W      16   width of iter_count
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  sample_valid in   1      new d/x sample available
//  sample_ready out  1      sequencer idle, sample accepted when valid&ready
//  adapt_freeze in   1      sampled at accept; 1 = skip weight update for this sample
//  fir_en       out  1      enable to FIR stage
//  fir_done     in   1      FIR stage finished
//  err_en       out  1      enable to error_check
//  err_done     in   1      error_check finished (done_errorcheck)
//  err_in       in   8      signed error e from error_check
//  upd_en       out  1      enable to weight-update stage
//  upd_tap      out  TAP_W  tap index being updated
//  upd_done     in   1      current tap update finished
//  out_valid    out  1      1-cycle pulse: sample fully processed
//  err_q        out  8      error captured for the current sample
//  converged    out  1      CONV_COUNT consecutive good samples seen
//  timeout_err  out  1      sticky: a stage exceeded TIMEOUT
//  iter_count   out  ITER_W completed samples, wraps to 0
// BEHAVIOUR
//  All outputs are registered except sample_ready = (state==IDLE).
//  After reset, state=IDLE, sample_ready=1, and all other outputs are 0.
//  FSM: IDLE -> FIR -> ERR -> UPD -> OUT -> IDLE.
//  IDLE: on sample_valid, latch adapt_freeze and go to FIR. fir_en=1 from the next cycle.
//  FIR: fir_en held high. fir_done is sampled every FIR cycle, including the first. On fir_done, go to ERR (fir_en=0, err_en=1).
//  ERR: err_en held high. On err_done, capture err_in into err_q.
//   Then go to UPD with upd_tap=0, or to OUT if freeze was latched.
//  UPD: upd_en held high. On each upd_done, upd_tap increments.
//   On upd_done with upd_tap==NTAPS-1, go to OUT with upd_en=0 and upd_tap=0.
//  OUT: out_valid=1 for exactly one cycle. iter_count+1 (modular wrap). Next state is IDLE.
//  A sample_valid presented during OUT is not accepted; it is accepted at the earliest in the following IDLE cycle.
//  |err_q|: two's-complement magnitude; -128 saturates to 127.
//  Good-sample counter (8b), updated in OUT:
//   - |err_q|<=CONV_THRESH: +1, saturating at CONV_COUNT.
//   - otherwise: cleared to 0.
//  converged = (counter==CONV_COUNT); it drops on the first bad sample. Frozen samples are still evaluated.
//  Watchdog: an 8b counter clears on every state entry and counts cycles spent in FIR/ERR/UPD.
//   - Also cleared on each upd_done.
//   - If it reaches TIMEOUT with no done: set timeout_err (sticky until reset), drop all enables, go to IDLE.
//   - No out_valid, iter_count unchanged.
//  *_done inputs are ignored in any state other than their own stage.
//  reset mid-operation: the next edge forces IDLE and zeroes all registered outputs and counters, including converged and timeout_err.
// TESTING
//  T1 reset; sample_valid=1; fir_done 3 cyc later; err_done w/ err_in=8'hFE; 4 upd_done -> upd_tap 0,1,2,3; out_valid 1 cyc;
//     err_q=8'hFE, iter_count=1
//  T2 adapt_freeze=1 at accept -> upd_en never 1; out_valid directly after err_done
//  T3 8 samples with err_in=2, then 1 with err_in=8'h80 -> converged rises on 8th out_valid, clears on 9th
//  T4 fir_done never asserted -> after 255 FIR cycles fir_en=0, timeout_err=1, sample_ready=1, iter_count unchanged
//  T5 reset asserted in UPD at upd_tap=2 -> next cycle all enables 0, upd_tap=0, converged=0, sample_ready=1
//  T6 stray err_done/upd_done in IDLE and FIR -> no state change; iter_count at 0xFFFF + sample -> wraps to 0

Source files
------------

// File: rtl/lms_step_sequencer_if.sv
// rtl/lms_step_sequencer_if.sv - handshake bundle between the LMS step sequencer and its stages
//
// Purpose: groups the sample-source handshake, the three stage enable/done
// pairs and the per-sample status outputs into one bundle.
//   master : the sequencer (drives enables, tap index, status)
//   slave  : the sample source and the fir/error_check/weight-update blocks
// Signals:
//   sample_valid/sample_ready/adapt_freeze  sample-source handshake
//   fir_en/fir_done                         FIR stage
//   err_en/err_done/err_in[7:0]             error_check stage (signed e)
//   upd_en/upd_tap/upd_done                 weight-update stage
//   out_valid/err_q/converged/timeout_err/iter_count  per-sample status

interface lms_step_sequencer_if #(
   parameter int TAP_W  = 2,
   parameter int ITER_W = 16
);
   logic              sample_valid;
   logic              sample_ready;
   logic              adapt_freeze;
   logic              fir_en;
   logic              fir_done;
   logic              err_en;
   logic              err_done;
   logic [7:0]        err_in;
   logic              upd_en;
   logic [TAP_W-1:0]  upd_tap;
   logic              upd_done;
   logic              out_valid;
   logic [7:0]        err_q;
   logic              converged;
   logic              timeout_err;
   logic [ITER_W-1:0] iter_count;

   modport master (
      input  sample_valid, adapt_freeze, fir_done, err_done, err_in, upd_done,
      output sample_ready, fir_en, err_en, upd_en, upd_tap,
             out_valid, err_q, converged, timeout_err, iter_count
   );

   modport slave (
      output sample_valid, adapt_freeze, fir_done, err_done, err_in, upd_done,
      input  sample_ready, fir_en, err_en, upd_en, upd_tap,
             out_valid, err_q, converged, timeout_err, iter_count
   );
endinterface

// File: rtl/lms_step_sequencer.sv
// rtl/lms_step_sequencer.sv - per-sample FIR / error / weight-update sequencer for the LMS filter
//
// Purpose: accepts one sample at a time and walks the datapath through the
// FIR, error_check and per-tap weight-update stages, then reports completion.
// Tracks consecutive small-error samples for a convergence flag and aborts a
// stalled stage with a watchdog.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    lms_step_sequencer_if.master (see interface file for signal list)
// Only sample_ready is combinational (state == IDLE); every other output is
// a register.

module lms_step_sequencer #(
   parameter int NTAPS       = 4,
   parameter int TAP_W       = 2,
   parameter int TIMEOUT     = 255,
   parameter int CONV_THRESH = 4,
   parameter int CONV_COUNT  = 8,
   parameter int ITER_W      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   lms_step_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIR,
      S_ERR,
      S_UPD,
      S_OUT
   } state_t;

   state_t            state, state_next;

   logic              freeze_q, freeze_next;
   logic              fir_en_q, fir_en_next;
   logic              err_en_q, err_en_next;
   logic              upd_en_q, upd_en_next;
   logic              out_valid_q, out_valid_next;
   logic              converged_q, converged_next;
   logic              timeout_q, timeout_next;
   logic [TAP_W-1:0]  tap_q, tap_next;
   logic [7:0]        err_q_r, err_q_next;
   logic [7:0]        wd_q, wd_next;
   logic [7:0]        good_q, good_next;
   logic [ITER_W-1:0] iter_q, iter_next;

   logic [7:0]        err_mag;
   logic              wd_expired;
   logic              tap_last;

   // Magnitude of the captured error; -128 has no positive twin in 8 bits,
   // so it is pinned to 127.
   always_comb begin
      err_mag = err_q_r;
      if (err_q_r == 8'h80) begin
         err_mag = 8'd127;
      end else if (err_q_r[7]) begin
         err_mag = (~err_q_r) + 8'd1;
      end
   end

   // The watchdog value counts cycles already spent in this stage, so the
   // TIMEOUT-th cycle without a done is the one where it equals TIMEOUT-1.
   assign wd_expired = (wd_q == 8'(TIMEOUT - 1));
   assign tap_last   = (tap_q == TAP_W'(NTAPS - 1));

   always_comb begin
      state_next     = state;
      freeze_next    = freeze_q;
      fir_en_next    = 1'b0;
      err_en_next    = 1'b0;
      upd_en_next    = 1'b0;
      out_valid_next = 1'b0;
      tap_next       = tap_q;
      err_q_next     = err_q_r;
      wd_next        = wd_q;
      good_next      = good_q;
      converged_next = converged_q;
      timeout_next   = timeout_q;
      iter_next      = iter_q;

      case (state)
         S_IDLE: begin
            if (bus.sample_valid) begin
               freeze_next = bus.adapt_freeze;
               state_next  = S_FIR;
               fir_en_next = 1'b1;
            end
         end

         S_FIR: begin
            fir_en_next = 1'b1;
            if (bus.fir_done) begin
               state_next  = S_ERR;
               fir_en_next = 1'b0;
               err_en_next = 1'b1;
            end else if (wd_expired) begin
               state_next   = S_IDLE;
               fir_en_next  = 1'b0;
               timeout_next = 1'b1;
            end else begin
               wd_next = wd_q + 8'd1;
            end
         end

         S_ERR: begin
            err_en_next = 1'b1;
            if (bus.err_done) begin
               err_q_next  = bus.err_in;
               err_en_next = 1'b0;
               if (freeze_q) begin
                  state_next     = S_OUT;
                  out_valid_next = 1'b1;
               end else begin
                  state_next  = S_UPD;
                  upd_en_next = 1'b1;
                  tap_next    = '0;
               end
            end else if (wd_expired) begin
               state_next   = S_IDLE;
               err_en_next  = 1'b0;
               timeout_next = 1'b1;
            end else begin
               wd_next = wd_q + 8'd1;
            end
         end

         S_UPD: begin
            upd_en_next = 1'b1;
            if (bus.upd_done) begin
               if (tap_last) begin
                  state_next     = S_OUT;
                  upd_en_next    = 1'b0;
                  tap_next       = '0;
                  out_valid_next = 1'b1;
               end else begin
                  tap_next = tap_q + TAP_W'(1);
                  // Each tap gets a fresh watchdog window.
                  wd_next  = '0;
               end
            end else if (wd_expired) begin
               state_next   = S_IDLE;
               upd_en_next  = 1'b0;
               tap_next     = '0;
               timeout_next = 1'b1;
            end else begin
               wd_next = wd_q + 8'd1;
            end
         end

         S_OUT: begin
            state_next = S_IDLE;
            iter_next  = iter_q + ITER_W'(1);
            // Frozen samples are judged too; err_q holds this sample's error.
            if (err_mag <= 8'(CONV_THRESH)) begin
               if (good_q != 8'(CONV_COUNT)) begin
                  good_next = good_q + 8'd1;
               end
            end else begin
               good_next = '0;
            end
            converged_next = (good_next == 8'(CONV_COUNT));
         end

         default: begin
            state_next = S_IDLE;
            tap_next   = '0;
         end
      endcase

      if (state_next != state) begin
         wd_next = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         freeze_q    <= 1'b0;
         fir_en_q    <= 1'b0;
         err_en_q    <= 1'b0;
         upd_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         converged_q <= 1'b0;
         timeout_q   <= 1'b0;
         tap_q       <= '0;
         err_q_r     <= '0;
         wd_q        <= '0;
         good_q      <= '0;
         iter_q      <= '0;
      end else begin
         state       <= state_next;
         freeze_q    <= freeze_next;
         fir_en_q    <= fir_en_next;
         err_en_q    <= err_en_next;
         upd_en_q    <= upd_en_next;
         out_valid_q <= out_valid_next;
         converged_q <= converged_next;
         timeout_q   <= timeout_next;
         tap_q       <= tap_next;
         err_q_r     <= err_q_next;
         wd_q        <= wd_next;
         good_q      <= good_next;
         iter_q      <= iter_next;
      end
   end

   assign bus.sample_ready = (state == S_IDLE);
   assign bus.fir_en       = fir_en_q;
   assign bus.err_en       = err_en_q;
   assign bus.upd_en       = upd_en_q;
   assign bus.upd_tap      = tap_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.err_q        = err_q_r;
   assign bus.converged    = converged_q;
   assign bus.timeout_err  = timeout_q;
   assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_lms_step_sequencer.sv
// tb/tb_lms_step_sequencer.sv - self-checking bench for lms_step_sequencer

module tb_lms_step_sequencer;
   localparam int NTAPS       = 4;
   localparam int TAP_W       = 2;
   localparam int TIMEOUT     = 255;
   localparam int CONV_THRESH = 4;
   localparam int CONV_COUNT  = 8;
   localparam int ITER_W      = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   lms_step_sequencer_if #(.TAP_W(TAP_W), .ITER_W(ITER_W)) bus ();

   lms_step_sequencer #(
      .NTAPS(NTAPS), .TAP_W(TAP_W), .TIMEOUT(TIMEOUT),
      .CONV_THRESH(CONV_THRESH), .CONV_COUNT(CONV_COUNT), .ITER_W(ITER_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [7:0]        err;
      logic [ITER_W-1:0] iter;
      logic              conv;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   model_iter = 0;
   int   model_good = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int err_abs(input logic [7:0] e);
      int v;
      v = int'($signed(e));
      if (v < 0) v = -v;
      if (v > 127) v = 127;
      return v;
   endfunction

   task automatic push_expect(input logic [7:0] e);
      exp_t x;
      model_iter = (model_iter + 1) % (1 << ITER_W);
      if (err_abs(e) <= CONV_THRESH) begin
         if (model_good < CONV_COUNT) model_good++;
      end else begin
         model_good = 0;
      end
      x.err  = e;
      x.iter = ITER_W'(model_iter);
      x.conv = (model_good == CONV_COUNT);
      sb.push_back(x);
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      bus.sample_valid = 1'b0;
      bus.adapt_freeze = 1'b0;
      bus.fir_done     = 1'b0;
      bus.err_done     = 1'b0;
      bus.err_in       = 8'h00;
      bus.upd_done     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
      sb.delete();
      model_iter = 0;
      model_good = 0;
   endtask

   // One sample through the pipeline; stop_tap >= 0 leaves the DUT parked in
   // UPD at that tap without finishing the sample.
   task automatic run_sample(input logic freeze, input logic [7:0] e, input int fir_wait,
                             input int stop_tap, input bit stray);
      int   n;
      exp_t x;
      check("ready_idle", 32'(bus.sample_ready), 1);
      bus.sample_valid = 1'b1;
      bus.adapt_freeze = freeze;
      push_expect(e);
      step();
      bus.sample_valid = 1'b0;
      bus.adapt_freeze = 1'b0;
      check("fir_en_on", 32'(bus.fir_en), 1);
      check("ready_busy", 32'(bus.sample_ready), 0);
      if (stray) begin
         bus.err_done = 1'b1;
         bus.upd_done = 1'b1;
         bus.err_in   = 8'h77;
         step();
         bus.err_done = 1'b0;
         bus.upd_done = 1'b0;
         bus.err_in   = 8'h00;
         check("stray_fir_en", 32'(bus.fir_en), 1);
         check("stray_err_en", 32'(bus.err_en), 0);
         check("stray_upd_en", 32'(bus.upd_en), 0);
      end
      repeat (fir_wait) step();
      check("fir_en_hold", 32'(bus.fir_en), 1);
      bus.fir_done = 1'b1;
      step();
      bus.fir_done = 1'b0;
      check("fir_en_off", 32'(bus.fir_en), 0);
      check("err_en_on", 32'(bus.err_en), 1);
      bus.err_done = 1'b1;
      bus.err_in   = e;
      step();
      bus.err_done = 1'b0;
      bus.err_in   = 8'h00;
      check("err_en_off", 32'(bus.err_en), 0);
      if (!freeze) begin
         for (int t = 0; t < NTAPS; t++) begin
            check("upd_en_on", 32'(bus.upd_en), 1);
            check("upd_tap", 32'(bus.upd_tap), t);
            if (t == stop_tap) return;
            bus.upd_done = 1'b1;
            step();
            bus.upd_done = 1'b0;
         end
      end
      n = 0;
      while (!bus.out_valid && n < 8) begin
         step();
         n++;
      end
      check("out_valid_seen", 32'(bus.out_valid), 1);
      check("out_latency", n, 0);
      check("upd_en_in_out", 32'(bus.upd_en), 0);
      check("upd_tap_in_out", 32'(bus.upd_tap), 0);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         x = sb.pop_front();
         check("err_q", 32'(bus.err_q), 32'(x.err));
         // A sample offered during OUT must wait for the next IDLE cycle.
         bus.sample_valid = 1'b1;
         step();
         bus.sample_valid = 1'b0;
         check("out_pulse_1cyc", 32'(bus.out_valid), 0);
         check("out_no_accept", 32'(bus.fir_en), 0);
         check("ready_after_out", 32'(bus.sample_ready), 1);
         check("iter_count", 32'(bus.iter_count), 32'(x.iter));
         check("converged", 32'(bus.converged), 32'(x.conv));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed stuck expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      logic [ITER_W-1:0] iter_before;

      clear_inputs();
      do_reset();
      check("rst_ready", 32'(bus.sample_ready), 1);
      check("rst_fir_en", 32'(bus.fir_en), 0);
      check("rst_err_en", 32'(bus.err_en), 0);
      check("rst_upd_en", 32'(bus.upd_en), 0);
      check("rst_upd_tap", 32'(bus.upd_tap), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_err_q", 32'(bus.err_q), 0);
      check("rst_converged", 32'(bus.converged), 0);
      check("rst_timeout", 32'(bus.timeout_err), 0);
      check("rst_iter", 32'(bus.iter_count), 0);

      // T1: full pass, negative error
      run_sample(1'b0, 8'hFE, 2, -1, 1'b0);
      check("t1_iter", 32'(bus.iter_count), 1);
      check("t1_err_q", 32'(bus.err_q), 32'h00FE);

      // T2: frozen sample skips UPD; large error clears the good run
      run_sample(1'b1, 8'h40, 0, -1, 1'b0);
      check("t2_upd_en", 32'(bus.upd_en), 0);

      // T3: eight good samples then -128
      for (int i = 0; i < 8; i++) begin
         run_sample(1'b0, 8'h02, 0, -1, 1'b0);
         check("t3_conv_step", 32'(bus.converged), (i == 7) ? 1 : 0);
      end
      run_sample(1'b0, 8'h80, 1, -1, 1'b0);
      check("t3_conv_drop", 32'(bus.converged), 0);

      // T4: FIR stage never completes
      iter_before = bus.iter_count;
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      n = 0;
      while (bus.fir_en && n < 300) begin
         if (bus.out_valid) check("t4_no_out_valid", 32'(bus.out_valid), 0);
         n++;
         step();
      end
      check("t4_fir_cycles", n, TIMEOUT);
      check("t4_fir_en", 32'(bus.fir_en), 0);
      check("t4_timeout", 32'(bus.timeout_err), 1);
      check("t4_ready", 32'(bus.sample_ready), 1);
      check("t4_out_valid", 32'(bus.out_valid), 0);
      check("t4_iter", 32'(bus.iter_count), 32'(iter_before));

      // Recovery; timeout_err stays set; threshold boundary and saturation
      run_sample(1'b0, 8'h05, 0, -1, 1'b0);
      check("t4_sticky", 32'(bus.timeout_err), 1);
      for (int i = 0; i < 9; i++) begin
         run_sample(i[0], (i == 8) ? 8'h04 : 8'hFC, 0, -1, 1'b0);
      end
      check("sat_conv", 32'(bus.converged), 1);

      // T5: reset while parked in UPD at tap 2
      run_sample(1'b0, 8'h01, 0, 2, 1'b0);
      reset = 1'b1;
      step();
      check("t5_fir_en", 32'(bus.fir_en), 0);
      check("t5_err_en", 32'(bus.err_en), 0);
      check("t5_upd_en", 32'(bus.upd_en), 0);
      check("t5_upd_tap", 32'(bus.upd_tap), 0);
      check("t5_converged", 32'(bus.converged), 0);
      check("t5_timeout", 32'(bus.timeout_err), 0);
      check("t5_ready", 32'(bus.sample_ready), 1);
      check("t5_iter", 32'(bus.iter_count), 0);
      reset = 1'b0;
      clear_inputs();
      sb.delete();
      model_iter = 0;
      model_good = 0;
      step();

      // T6: stray dones in IDLE, then in FIR
      bus.err_done = 1'b1;
      bus.upd_done = 1'b1;
      bus.err_in   = 8'h55;
      step();
      clear_inputs();
      check("t6_idle_ready", 32'(bus.sample_ready), 1);
      check("t6_idle_err_en", 32'(bus.err_en), 0);
      check("t6_idle_upd_en", 32'(bus.upd_en), 0);
      check("t6_idle_err_q", 32'(bus.err_q), 0);
      check("t6_idle_out", 32'(bus.out_valid), 0);
      run_sample(1'b0, 8'h03, 1, -1, 1'b1);

      // iter_count wrap
      n = 0;
      while (model_iter != (1 << ITER_W) - 1 && n < 400) begin
         run_sample(1'b1, 8'h01, 0, -1, 1'b0);
         n++;
      end
      check("wrap_pre", 32'(bus.iter_count), (1 << ITER_W) - 1);
      run_sample(1'b1, 8'h01, 0, -1, 1'b0);
      check("wrap_zero", 32'(bus.iter_count), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
